// File: rtl/crc8_frame_check_if.sv
// crc8_frame_check_if: serial-bit frame bus between a bit source (master) and the CRC8 frame checker (slave)
// Signals: ce/xin/sof driven by the master; byte_out, byte_valid, crc_calc, busy, done, crc_ok, crc_err
// returned by the checker, plus err_cnt when CRC8_FRAME_ERRCNT_EN is defined.
interface crc8_frame_check_if;
  logic       ce;
  logic       xin;
  logic       sof;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [7:0] crc_calc;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic       crc_err;
`ifdef CRC8_FRAME_ERRCNT_EN
  logic [7:0] err_cnt;
`endif
  modport master (
    output ce, xin, sof,
    input  byte_out, byte_valid, crc_calc, busy, done, crc_ok, crc_err
`ifdef CRC8_FRAME_ERRCNT_EN
    , err_cnt
`endif
  );
  modport slave (
    input  ce, xin, sof,
    output byte_out, byte_valid, crc_calc, busy, done, crc_ok, crc_err
`ifdef CRC8_FRAME_ERRCNT_EN
    , err_cnt
`endif
  );
endinterface

// File: rtl/crc8_frame_check.sv
// crc8_frame_check: deserialises LSB-first frames of NBYTES payload bytes plus a CRC8 (0x31, init 0xFF) byte and checks it
// Ports: clk, rst (sync, active-high), bus (crc8_frame_check_if.slave).
// Optional: define CRC8_FRAME_ERRCNT_EN to add a saturating 8-bit count of failed frames on bus.err_cnt.
module crc8_frame_check #(
  parameter int NBYTES = 4
) (
  input logic              clk,
  input logic              rst,
  crc8_frame_check_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CRCB, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] buf_q, buf_d, crc_q, crc_d, byte_out_q, byte_out_d, byte_cnt_q, byte_cnt_d, nbuf;
  logic [2:0] bit_q, bit_d;
  logic       byte_valid_q, byte_valid_d, done_q, done_d, crc_ok_q, crc_ok_d, crc_err_q, crc_err_d;
  logic       start, shift;
  function automatic logic [7:0] crc8(input logic [7:0] v);
    logic [7:0] c;
    c = v;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ 8'h31 : {c[6:0], 1'b0};
    return c;
  endfunction
  // bytes arrive LSB first, so shifting in from the MSB side leaves them in natural order
  assign nbuf  = {bus.xin, buf_q[7:1]};
  assign start = bus.ce & bus.sof;
  assign shift = bus.ce & (state_q == PAYLOAD || state_q == CRCB);
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    crc_d        = crc_q;
    bit_d        = bit_q;
    byte_cnt_d   = byte_cnt_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    done_d       = 1'b0;
    crc_ok_d     = crc_ok_q;
    crc_err_d    = crc_err_q;
    if (start) begin
      state_d    = PAYLOAD;
      buf_d      = nbuf;
      crc_d      = 8'hFF;
      bit_d      = 3'd1;
      byte_cnt_d = 8'd0;
    end else if (shift) begin
      buf_d = nbuf;
      bit_d = bit_q + 3'd1;
      if (bit_q == 3'd7) begin
        byte_out_d   = nbuf;
        byte_valid_d = 1'b1;
        if (state_q == PAYLOAD) begin
          crc_d      = crc8(crc_q ^ nbuf);
          byte_cnt_d = byte_cnt_q + 8'd1;
          state_d    = byte_cnt_q == 8'(NBYTES - 1) ? CRCB : PAYLOAD;
        end else begin
          state_d   = DONE;
          done_d    = 1'b1;
          crc_ok_d  = nbuf == crc_q;
          crc_err_d = nbuf != crc_q;
        end
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_q        <= 8'h00;
      crc_q        <= 8'hFF;
      bit_q        <= 3'd0;
      byte_cnt_q   <= 8'd0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      crc_q        <= crc_d;
      bit_q        <= bit_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
      crc_ok_q     <= crc_ok_d;
      crc_err_q    <= crc_err_d;
    end
  end
  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.crc_calc   = crc_q;
  assign bus.busy       = state_q == PAYLOAD || state_q == CRCB;
  assign bus.done       = done_q;
  assign bus.crc_ok     = crc_ok_q;
  assign bus.crc_err    = crc_err_q;
`ifdef CRC8_FRAME_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  assign err_cnt_d = (done_d && crc_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else err_cnt_q <= err_cnt_d;
  end
  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_crc8_frame_check.sv
// tb_crc8_frame_check: randomized self-checking bench for crc8_frame_check against a polynomial-division CRC model
module tb_crc8_frame_check;
  localparam int NB = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  crc8_frame_check_if bus();
  crc8_frame_check #(.NBYTES(NB)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int exp_err_cnt = 0;
  logic [7:0] fr [NB+1];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask
  // remainder of ((crc ^ byte) * x^8) modulo x^8+x^5+x^4+1
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] v;
    v = {c ^ b, 8'h00};
    for (int k = 15; k >= 8; k--) if (v[k]) v = v ^ (16'h0131 << (k - 8));
    return v[7:0];
  endfunction
  function automatic logic [7:0] model_crc();
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 0; i < NB; i++) c = crc_ref(c, fr[i]);
    return c;
  endfunction
  task automatic send_bit(input logic b, input logic s);
    bus.ce = 1'b1;
    bus.xin = b;
    bus.sof = s;
    @(negedge clk);
    bus.ce = 1'b0;
    bus.sof = 1'b0;
  endtask
  // idle cycles toggle sof without ce, which must have no effect
  task automatic idle(input int n);
    repeat (n) begin
      bus.sof = 1'($urandom);
      bus.xin = 1'($urandom);
      @(negedge clk);
      chk("bv_idle", 32'(bus.byte_valid), 32'd0);
      chk("done_idle", 32'(bus.done), 32'd0);
    end
    bus.sof = 1'b0;
  endtask
  task automatic run_frame(input int gmin, input int gmax);
    logic [7:0] c;
    logic ok;
    c = 8'hFF;
    for (int i = 0; i <= NB; i++) begin
      for (int j = 0; j < 8; j++) begin
        send_bit(fr[i][j], i == 0 && j == 0);
        chk("bv", 32'(bus.byte_valid), 32'(j == 7));
        chk("done", 32'(bus.done), 32'(i == NB && j == 7));
        chk("busy", 32'(bus.busy), 32'(!(i == NB && j == 7)));
        if (i == 0 && j == 0) chk("crc_init", 32'(bus.crc_calc), 32'h00FF);
        if (j == 7) begin
          chk("byte_out", 32'(bus.byte_out), 32'(fr[i]));
          if (i < NB) c = crc_ref(c, fr[i]);
          chk("crc_calc", 32'(bus.crc_calc), 32'(c));
          if (i == NB) begin
            ok = fr[NB] == c;
            chk("crc_ok", 32'(bus.crc_ok), 32'(ok));
            chk("crc_err", 32'(bus.crc_err), 32'(!ok));
`ifdef CRC8_FRAME_ERRCNT_EN
            if (!ok && exp_err_cnt < 255) exp_err_cnt++;
            chk("err_cnt", 32'(bus.err_cnt), 32'(exp_err_cnt));
`endif
          end
        end
        idle($urandom_range(gmax, gmin));
      end
    end
  endtask
  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) begin
      send_bit(1'($urandom), k == 0);
      chk("done_part", 32'(bus.done), 32'd0);
      chk("bv_part", 32'(bus.byte_valid), 32'(k % 8 == 7));
    end
  endtask
  task automatic reset_check();
    rst = 1'b1;
    bus.ce = 1'b1;
    bus.sof = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_byte_out", 32'(bus.byte_out), 32'd0);
    chk("rst_crc", 32'(bus.crc_calc), 32'h00FF);
    chk("rst_bv", 32'(bus.byte_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ok", 32'(bus.crc_ok), 32'd0);
    chk("rst_err", 32'(bus.crc_err), 32'd0);
`ifdef CRC8_FRAME_ERRCNT_EN
    exp_err_cnt = 0;
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    rst = 1'b0;
    bus.ce = 1'b0;
    bus.sof = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
  endtask
  task automatic rand_frame(input logic good);
    for (int i = 0; i < NB; i++) fr[i] = 8'($urandom);
    fr[NB] = good ? model_crc() : 8'($urandom);
  endtask
  initial begin
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.xin = 1'b0;
    bus.sof = 1'b0;
    reset_check();
    fr[0] = 8'hFF; fr[1] = 8'hFF; fr[2] = 8'hAC;
    run_frame(0, 0);
    chk("crc_fixed", 32'(bus.crc_calc), 32'h00AC);
    idle(3);
    chk("ok_hold", 32'(bus.crc_ok), 32'd1);
    chk("byte_hold", 32'(bus.byte_out), 32'h00AC);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    run_frame(2, 2);
    fr[2] = 8'hAD;
    run_frame(0, 1);
    idle(2);
    chk("err_hold", 32'(bus.crc_err), 32'd1);
    for (int n = 0; n < 30; n++) begin
      rand_frame(1'($urandom));
      run_frame(0, $urandom_range(2, 0));
    end
    send_partial(13);
    rand_frame(1'b1);
    run_frame(0, 1);
    send_partial(NB * 8 + 4);
    reset_check();
    rand_frame(1'b1);
    run_frame(0, 0);
`ifdef CRC8_FRAME_ERRCNT_EN
    fr[0] = 8'h00; fr[1] = 8'h00; fr[2] = ~model_crc();
    repeat (300) run_frame(0, 0);
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'h00FF);
`endif
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
